// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words drained from the FIFO.
// A word transfers on a rising clk edge where valid and ready are both high; once valid
// is raised, valid and data hold unchanged until that transfer happens.
interface fifo_rd_stream_if #(
  parameter int W = 16
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: prefetches up to three words into a small ring so the stream
// runs at one word per clock despite the FIFO's one-cycle read latency.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_rd_stream_if.master      m,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_underflow,
  output logic [1:0]            dbg_occ,
  output logic                  dbg_pending
);

  logic [FIFO_WIDTH-1:0] mem [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            occ;
  logic                  pending;
  logic [2:0]            inflight;
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads in flight count against capacity, so no issued read can find the ring full.
  always_comb begin
    inflight   = {1'b0, occ} + {2'b00, pending};
    fifo_rd_en = rst_n & ~flush & ~fifo_empty & (inflight < 3'd3);
    capture    = pending & ~flush;
    pop        = (occ != 2'd0) & m.ready & ~flush;
  end

  assign m.valid     = (occ != 2'd0);
  assign m.data      = mem[rd_ptr];
  assign dbg_occ     = occ;
  assign dbg_pending = pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= 2'd0;
      rd_ptr        <= 2'd0;
      occ           <= 2'd0;
      pending       <= 1'b0;
      rd_count      <= '0;
      err_underflow <= 1'b0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      pending <= fifo_rd_en;
      if (pending && fifo_underflow) err_underflow <= 1'b1;
      if (flush) begin
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
        occ    <= 2'd0;
      end else begin
        if (capture) begin
          mem[wr_ptr] <= fifo_data_out;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr   <= ptr_inc(rd_ptr);
          rd_count <= rd_count + CNT_WIDTH'(1);
        end
        case ({capture, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO model, vector table for the streaming case,
// hand sequences for backpressure, toggling ready, flush, underflow and mid-stream reset.
module tb_fifo_rd_stream;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_underflow = 1'b0;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_rd_en;
  logic         flush = 1'b0;
  logic [15:0]  rd_count;
  logic         err_underflow;
  logic [1:0]   dbg_occ;
  logic         dbg_pending;

  fifo_rd_stream_if #(.W(W)) m_if ();

  fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m              (m_if),
    .flush          (flush),
    .rd_count       (rd_count),
    .err_underflow  (err_underflow),
    .dbg_occ        (dbg_occ),
    .dbg_pending    (dbg_pending)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  int           acc_cnt = 0;
  int           issued_cnt = 0;
  bit           sb_on = 1'b0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        m_ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_rd_en;
    logic [15:0] exp_count;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fifo_push(input logic [W-1:0] v, input bit to_exp);
    fifo_q.push_back(v);
    if (to_exp) exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample handshakes before the edge, then the FIFO model answers a read.
  task automatic tick();
    logic iss;
    #1;
    iss = fifo_rd_en;
    if (iss) issued_cnt++;
    if (m_if.valid && m_if.ready && !flush) begin
      acc_cnt++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra_word actual=0x%0h expected=none", m_if.data);
        end else begin
          check("sb_data", m_if.data, exp_q.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    if (iss && fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    flush          = 1'b0;
    m_if.ready     = 1'b0;
    fifo_underflow = 1'b0;
    sb_on          = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty     = 1'b1;
    fifo_data_out  = '0;
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", m_if.valid, 0);
    check("rst_data", m_if.data, 0);
    check("rst_count", rd_count, 0);
    check("rst_err", err_underflow, 0);
    check("rst_occ", dbg_occ, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    acc_cnt    = 0;
    issued_cnt = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming 0x0001..0x0008 with ready held high; row i is the state after edge i+1.
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'd1};
    vecs[3] = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'd2};
    vecs[4] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'd3};
    vecs[5] = '{1'b1, 1'b1, 16'h0005, 1'b1, 16'd4};
    vecs[6] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'd5};
    vecs[7] = '{1'b1, 1'b1, 16'h0007, 1'b0, 16'd6};
    vecs[8] = '{1'b1, 1'b1, 16'h0008, 1'b0, 16'd7};
    vecs[9] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'd8};

    do_reset();
    for (int i = 1; i <= 8; i++) fifo_push(W'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      m_if.ready = vecs[i].m_ready;
      tick();
      check($sformatf("vec%0d_valid", i), m_if.valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), m_if.data, vecs[i].exp_data);
      check($sformatf("vec%0d_rd_en", i), fifo_rd_en, vecs[i].exp_rd_en);
      check($sformatf("vec%0d_count", i), rd_count, vecs[i].exp_count);
    end

    // Backpressure: ten words queued, ready low for ten cycles.
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 10; i++) fifo_push(16'h0101 + W'(i), 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) check("bp_data_mid", m_if.data, 16'h0101);
    end
    check("bp_rd_pulses", issued_cnt, 3);
    check("bp_occ", dbg_occ, 3);
    check("bp_rd_en_low", fifo_rd_en, 0);
    check("bp_valid", m_if.valid, 1);
    check("bp_data_hold", m_if.data, 16'h0101);
    m_if.ready = 1'b1;
    for (int i = 0; i < 40 && acc_cnt < 10; i++) tick();
    check("bp_accepted", acc_cnt, 10);
    check("bp_exp_left", exp_q.size(), 0);
    check("bp_count", rd_count, 10);
    check("bp_drained", m_if.valid, 0);

    // Ready toggling against a fed FIFO.
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 24; i++) fifo_push(16'hA000 + W'(i), 1'b1);
    for (int i = 0; i < 24; i++) begin
      m_if.ready = (i % 2 == 0);
      tick();
    end
    m_if.ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    check("tog_accepted", acc_cnt, 24);
    check("tog_count", rd_count, 24);

    // Flush with two buffered words and a read in flight.
    do_reset();
    fifo_push(16'h0011, 1'b0);
    fifo_push(16'h0012, 1'b0);
    fifo_push(16'h0013, 1'b0);
    fifo_push(16'h00FF, 1'b0);
    repeat (3) tick();
    check("fl_pre_occ", dbg_occ, 2);
    check("fl_pre_pending", dbg_pending, 1);
    check("fl_pre_data", m_if.data, 16'h0011);
    flush      = 1'b1;
    m_if.ready = 1'b1;
    #1;
    check("fl_rd_en", fifo_rd_en, 0);
    tick();
    flush = 1'b0;
    check("fl_valid", m_if.valid, 0);
    check("fl_count", rd_count, 0);
    check("fl_occ", dbg_occ, 0);
    exp_q.push_back(16'h00FF);
    sb_on = 1'b1;
    tick();
    check("fl_post_valid0", m_if.valid, 0);
    tick();
    check("fl_post_valid1", m_if.valid, 1);
    check("fl_post_data", m_if.data, 16'h00FF);
    tick();
    check("fl_post_count", rd_count, 1);
    check("fl_post_exp_left", exp_q.size(), 0);

    // Underflow flag: ignored without a pending read, sticky through flush.
    do_reset();
    fifo_underflow = 1'b1;
    tick();
    check("uf_no_pending", err_underflow, 0);
    fifo_underflow = 1'b0;
    fifo_push(16'h0055, 1'b0);
    tick();
    check("uf_pending", dbg_pending, 1);
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    check("uf_set", err_underflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("uf_after_flush", err_underflow, 1);
    tick();
    check("uf_sticky", err_underflow, 1);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 6; i++) fifo_push(16'h0200 + W'(i), 1'b0);
    m_if.ready = 1'b1;
    repeat (4) tick();
    check("ar_pre_count", rd_count, 2);
    check("ar_pre_rd_en", fifo_rd_en, 1);
    m_if.ready = 1'b0;
    tick();
    check("ar_pre_occ", dbg_occ, 2);
    rst_n = 1'b0;
    #1;
    check("ar_rd_en", fifo_rd_en, 0);
    check("ar_valid", m_if.valid, 0);
    check("ar_count", rd_count, 0);
    check("ar_occ", dbg_occ, 0);
    check("ar_pending", dbg_pending, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter that sits directly downstream of the synchronous FIFO. It drains the FIFO through its rd_en/data_out/empty port and presents the words on a valid/ready stream. It hides the FIFO's one-cycle read latency behind a 3-entry prefetch buffer, so the stream sustains one word per clock. It also counts delivered words and flags unexpected FIFO underflows.

## Interface
- FIFO_WIDTH, 16, width of FIFO data words and of m_data
- CNT_WIDTH, 16, width of the delivered-word counter
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- fifo_empty  input  1  FIFO empty flag
- fifo_underflow  input  1  FIFO underflow flag (read attempted while empty)
- fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted read
- fifo_rd_en  output  1  read request to FIFO
- m_valid  output  1  stream word available
- m_ready  input  1  downstream accepts word
- m_data  output  FIFO_WIDTH  stream word (head of buffer)
- flush  input  1  synchronous discard of buffered and in-flight words
- rd_count  output  CNT_WIDTH  number of completed stream handshakes, wraps modulo 2^CNT_WIDTH
- err_underflow  output  1  sticky: FIFO reported underflow on a read this block issued

## Operation
- State: 3-entry circular buffer (wr_ptr, rd_ptr 2-bit, occ 0..3), pending bit (read issued last cycle), rd_count, err_underflow.
- Issue rule: fifo_rd_en = rst_n & !flush & !fifo_empty & (occ + pending < 3). No combinational path from m_ready to fifo_rd_en.
- pending <= fifo_rd_en every cycle.
- Capture: when pending=1 and flush=0, fifo_data_out is written at wr_ptr, and wr_ptr advances. The word is discarded when flush=1.
- Pop: m_valid = (occ != 0); m_data = buffer[rd_ptr]. When m_valid & m_ready, rd_ptr advances and rd_count increments.
- Pointers wrap 2->0. occ_next = occ + capture - pop. A simultaneous capture and pop leaves occ unchanged.
- Capture never occurs at occ=3; this is guaranteed by the issue rule.
- err_underflow is set when pending=1 and fifo_underflow=1. It is cleared only by reset; flush does not clear it.
- Flush takes priority over everything except reset. It sets occ=0 and rd_ptr=wr_ptr=0, and forces pending to 0 next cycle. No pop is counted in a flush cycle even if m_ready=1. rd_count is preserved.
- m_data is don't-care while m_valid=0; the bench must not check it.

## Timing
- Reset (rst_n low, asynchronous): fifo_rd_en=0 immediately; m_valid=0, m_data=0, rd_count=0, err_underflow=0, occ=0, pending=0, pointers=0.
- The first read may issue in the first cycle after rst_n deasserts, if fifo_empty=0.
- Latency: rd_en high at edge N → data captured at edge N+1 → m_valid high after edge N+1. That is 1 cycle from read issue to stream valid, or 2 cycles from fifo_empty falling with an idle block.
- Throughput: 1 word/cycle sustained with m_ready held high and FIFO non-empty.
- Backpressure: with m_ready=0, at most 3 words are read ahead. fifo_rd_en drops when occ+pending=3.
- m_valid/m_data stay stable while m_valid=1 and m_ready=0; no word is dropped or duplicated.
- Reset mid-transfer: the in-flight word is lost and the buffer is emptied. The FIFO must be reset together with this block.

## Test plan
- Reset then push 0x0001..0x0008 into FIFO, m_ready=1 → m_data sequence 0x0001..0x0008 on 8 consecutive cycles, first m_valid 2 cycles after fifo_empty falls, rd_count=8.
- FIFO holding 10 words, m_ready=0 for 10 cycles → exactly 3 fifo_rd_en pulses, occ=3, m_data=first word held stable. Then m_ready=1 → all 10 words delivered in order.
- Toggle m_ready 1,0,1,0 with FIFO continuously fed 0xA000+i → no gap or duplicate in the accepted sequence; rd_count equals the number of accepted cycles.
- flush asserted with occ=2 and pending=1 → next cycle m_valid=0, captured word discarded, rd_count unchanged. The next FIFO word 0x00FF is delivered as first post-flush word.
- Drive fifo_underflow=1 in a cycle where pending=1 → err_underflow=1 and stays high through a flush; cleared only by rst_n=0.
- Assert rst_n=0 mid-stream with occ=2 → fifo_rd_en and m_valid go 0 asynchronously, and rd_count=0.
